alloc_bitmap_16: RTL and testbench

- Free-entry allocator for the 16-entry tracking structures in the core (TLB fill slots, miss-status entries).
- Keeps an occupancy bitmap and grants the lowest-numbered free entry.
- Grant is produced both as a strict one-hot vector (feeds the 16-to-4 one-hot encoder) and as a binary index.
- Releases arrive as binary indices and are decoded internally to one-hot clear masks (4-to-16 decode).

---
 rtl/alloc_bitmap_16.sv | 77 +++++++
 tb/tb_alloc_bitmap_16.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alloc_bitmap_16.sv
// Free-entry allocator: occupancy bitmap that grants the lowest free entry as one-hot and index,
// releases by binary index, and flags releases of already-free entries.
module alloc_bitmap_16 #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               alloc_req,
    output logic               alloc_ready,
    output logic               alloc_fire,
    output logic [ENTRIES-1:0] alloc_onehot,
    output logic [IDX_W-1:0]   alloc_idx,
    input  logic               free_valid,
    input  logic [IDX_W-1:0]   free_idx,
    input  logic               flush,
    output logic [IDX_W:0]     used_cnt,
    output logic               full,
    output logic               empty,
    output logic               err_dfree
);

    logic [ENTRIES-1:0] occ_q, occ_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [ENTRIES-1:0] set_mask;
    logic [ENTRIES-1:0] clr_mask;
    logic               free_hit;

    // Adding one to the bitmap ripples through the trailing ones, isolating the lowest zero.
    assign alloc_onehot = ~occ_q & (occ_q + ENTRIES'(1));
    assign alloc_ready  = ~&occ_q;
    assign alloc_fire   = alloc_req && alloc_ready && !flush;
    assign full         = &occ_q;
    assign empty        = ~|occ_q;
    assign used_cnt     = cnt_q;
    assign err_dfree    = err_q;

    always_comb begin
        alloc_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (alloc_onehot[i]) begin
                alloc_idx = alloc_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        set_mask = alloc_fire ? alloc_onehot : '0;
        clr_mask = free_valid ? (ENTRIES'(1) << free_idx) : '0;
        free_hit = free_valid && occ_q[free_idx];

        occ_d = (occ_q & ~clr_mask) | set_mask;
        cnt_d = cnt_q + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, free_hit};
        err_d = free_valid && !occ_q[free_idx];

        if (flush) begin
            occ_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_alloc_bitmap_16.sv
// Self-checking bench for alloc_bitmap_16: directed scenarios plus a long random run
// against an array-based occupancy model.
module tb_alloc_bitmap_16;

    logic        clk;
    logic        resetn;
    logic        alloc_req;
    logic        alloc_ready;
    logic        alloc_fire;
    logic [15:0] alloc_onehot;
    logic [3:0]  alloc_idx;
    logic        free_valid;
    logic [3:0]  free_idx;
    logic        flush;
    logic [4:0]  used_cnt;
    logic        full;
    logic        empty;
    logic        err_dfree;

    int checks;
    int failures;

    bit m_occ[16];
    bit m_err;

    alloc_bitmap_16 dut (
        .clk          (clk),
        .resetn       (resetn),
        .alloc_req    (alloc_req),
        .alloc_ready  (alloc_ready),
        .alloc_fire   (alloc_fire),
        .alloc_onehot (alloc_onehot),
        .alloc_idx    (alloc_idx),
        .free_valid   (free_valid),
        .free_idx     (free_idx),
        .flush        (flush),
        .used_cnt     (used_cnt),
        .full         (full),
        .empty        (empty),
        .err_dfree    (err_dfree)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_lowest();
        for (int i = 0; i < 16; i++) begin
            if (!m_occ[i]) return i;
        end
        return 16;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_occ[i]);
        return n;
    endfunction

    task automatic drive(input logic rq, input logic fv, input logic [3:0] fi, input logic fl,
                         input logic rn);
        alloc_req  = rq;
        free_valid = fv;
        free_idx   = fi;
        flush      = fl;
        resetn     = rn;
    endtask

    // Advance the model by one clock from the currently driven inputs, then move to the negedge.
    task automatic step();
        int lo;
        lo = m_lowest();
        if (!resetn || flush) begin
            for (int i = 0; i < 16; i++) m_occ[i] = 1'b0;
            m_err = 1'b0;
        end else begin
            m_err = free_valid && !m_occ[free_idx];
            if (free_valid) m_occ[free_idx] = 1'b0;
            if (alloc_req && lo < 16) m_occ[lo] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (used_cnt !== 5'd0) begin
            failures++; $display("FAIL reset_used_cnt got=%0d want=0", used_cnt);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++; $display("FAIL reset_empty_full got=%b%b want=10", empty, full);
        end
        checks++;
        if (alloc_onehot !== 16'h0001 || alloc_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_grant got=%h/%0d want=0001/0", alloc_onehot, alloc_idx);
        end
        checks++;
        if (err_dfree !== 1'b0 || alloc_ready !== 1'b1) begin
            failures++; $display("FAIL reset_err_ready got=%b%b want=01", err_dfree, alloc_ready);
        end
    endtask

    task automatic test_fill();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (alloc_idx !== 4'(i) || alloc_fire !== 1'b1) begin
                failures++;
                $display("FAIL fill_idx cycle=%0d got=%0d/%b want=%0d/1", i, alloc_idx, alloc_fire, i);
            end
            step();
        end
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || full !== 1'b1 || alloc_fire !== 1'b0) begin
            failures++;
            $display("FAIL fill_full got ready=%b full=%b fire=%b want 0 1 0",
                     alloc_ready, full, alloc_fire);
        end
        checks++;
        if (used_cnt !== 5'd16 || alloc_onehot !== 16'h0000 || alloc_idx !== 4'd0) begin
            failures++;
            $display("FAIL fill_cnt got=%0d/%h/%0d want=16/0000/0", used_cnt, alloc_onehot, alloc_idx);
        end
        step();
        checks++;
        if (used_cnt !== 5'd16) begin
            failures++; $display("FAIL full_retry got=%0d want=16", used_cnt);
        end
    endtask

    task automatic test_free_realloc();
        drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        step();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (alloc_idx !== 4'd5 || alloc_onehot !== 16'h0020 || used_cnt !== 5'd15) begin
            failures++;
            $display("FAIL realloc got=%0d/%h/%0d want=5/0020/15", alloc_idx, alloc_onehot, used_cnt);
        end
        step();
        checks++;
        if (full !== 1'b1 || used_cnt !== 5'd16) begin
            failures++; $display("FAIL realloc_full got=%b/%0d want=1/16", full, used_cnt);
        end
    endtask

    task automatic test_same_cycle();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (8) step();
        drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b1);
        #1;
        checks++;
        if (alloc_idx !== 4'd8 || alloc_fire !== 1'b1) begin
            failures++; $display("FAIL same_grant got=%0d/%b want=8/1", alloc_idx, alloc_fire);
        end
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (used_cnt !== 5'd8 || alloc_idx !== 4'd2 || err_dfree !== 1'b0) begin
            failures++;
            $display("FAIL same_next got=%0d/%0d/%b want=8/2/0", used_cnt, alloc_idx, err_dfree);
        end
    endtask

    task automatic test_double_free();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (2) step();
        drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (err_dfree !== 1'b1 || used_cnt !== 5'd2 || alloc_idx !== 4'd2) begin
            failures++;
            $display("FAIL dfree_pulse got=%b/%0d/%0d want=1/2/2", err_dfree, used_cnt, alloc_idx);
        end
        step();
        checks++;
        if (err_dfree !== 1'b0) begin
            failures++; $display("FAIL dfree_one_cycle got=%b want=0", err_dfree);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (14) step();
        drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
        #1;
        checks++;
        if (full !== 1'b1 || alloc_fire !== 1'b0) begin
            failures++; $display("FAIL flush_fire got full=%b fire=%b want 1 0", full, alloc_fire);
        end
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (empty !== 1'b1 || used_cnt !== 5'd0 || err_dfree !== 1'b0) begin
            failures++;
            $display("FAIL flush_state got=%b/%0d/%b want=1/0/0", empty, used_cnt, err_dfree);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (5) step();
        drive(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (used_cnt !== 5'd0 || alloc_idx !== 4'd0 || err_dfree !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%0d/%0d/%b want=0/0/0", used_cnt, alloc_idx, err_dfree);
        end
    endtask

    task automatic test_random();
        int lo, start, cnt;
        logic rq, fv, fl, rn;
        logic [3:0] fi;
        logic [15:0] exp_oh;
        for (int n = 0; n < 10000; n++) begin
            rq = ($urandom_range(99) < 60);
            fv = ($urandom_range(99) < 45);
            fl = ($urandom_range(299) == 0);
            rn = ($urandom_range(999) != 0);
            fi = 4'($urandom_range(15));
            // Mostly release an occupied entry so the bitmap drains as well as fills.
            if ($urandom_range(3) != 0) begin
                start = $urandom_range(15);
                for (int k = 0; k < 16; k++) begin
                    if (m_occ[(start + k) % 16]) begin
                        fi = 4'((start + k) % 16);
                        break;
                    end
                end
            end
            drive(rq, fv, fi, fl, rn);
            #1;
            lo = m_lowest();
            cnt = m_count();
            exp_oh = (lo < 16) ? (16'h0001 << lo) : 16'h0000;
            checks++;
            if (used_cnt !== 5'(cnt)) begin
                failures++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, used_cnt, cnt);
            end
            checks++;
            if (alloc_onehot !== exp_oh || !$onehot0(alloc_onehot)) begin
                failures++; $display("FAIL rnd_onehot n=%0d got=%h want=%h", n, alloc_onehot, exp_oh);
            end
            checks++;
            if (alloc_idx !== ((lo < 16) ? 4'(lo) : 4'd0)) begin
                failures++; $display("FAIL rnd_idx n=%0d got=%0d want=%0d", n, alloc_idx, lo);
            end
            checks++;
            if (alloc_ready !== (lo < 16) || alloc_fire !== (rq && lo < 16 && !fl)) begin
                failures++;
                $display("FAIL rnd_handshake n=%0d got=%b%b want=%b%b", n, alloc_ready, alloc_fire,
                         lo < 16, rq && lo < 16 && !fl);
            end
            checks++;
            if (full !== (cnt == 16) || empty !== (cnt == 0)) begin
                failures++;
                $display("FAIL rnd_full_empty n=%0d got=%b%b want=%b%b", n, full, empty,
                         cnt == 16, cnt == 0);
            end
            checks++;
            if (err_dfree !== m_err) begin
                failures++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, err_dfree, m_err);
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_err = 1'b0;
        for (int i = 0; i < 16; i++) m_occ[i] = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_fill();
        test_free_realloc();
        test_same_cycle();
        test_double_free();
        test_flush();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
